// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the control sequencer and its decoder.
//   - opcode constants for ir[15:12]
//   - function-select (FS) codes seen by the ALU and the carry-in logic
//   - sequencer state encoding
//   - instruction field positions and field-extraction helpers
package cpu_pkg;

  // Opcodes
  localparam logic [3:0] OP_MOVA = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_MOVB = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hC;
  localparam logic [3:0] OP_ST   = 4'hD;
  localparam logic [3:0] OP_BRZ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Function-select codes
  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_INC  = 4'b0001;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_DEC  = 4'b0110;
  localparam logic [3:0] FS_AND  = 4'b1000;
  localparam logic [3:0] FS_OR   = 4'b1001;
  localparam logic [3:0] FS_XOR  = 4'b1010;
  localparam logic [3:0] FS_NOT  = 4'b1011;
  localparam logic [3:0] FS_MOVB = 4'b1100;
  localparam logic [3:0] FS_SHR  = 4'b1101;
  localparam logic [3:0] FS_SHL  = 4'b1110;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Instruction field positions (LSB of each field)
  localparam int IR_OP_LSB = 12;
  localparam int IR_DR_LSB = 9;
  localparam int IR_SA_LSB = 6;
  localparam int IR_SB_LSB = 3;

  function automatic logic [3:0] ir_op(input logic [15:0] ir);
    return ir[IR_OP_LSB +: 4];
  endfunction

  function automatic logic [2:0] ir_dr(input logic [15:0] ir);
    return ir[IR_DR_LSB +: 3];
  endfunction

  function automatic logic [2:0] ir_sa(input logic [15:0] ir);
    return ir[IR_SA_LSB +: 3];
  endfunction

  function automatic logic [2:0] ir_sb(input logic [15:0] ir);
    return ir[IR_SB_LSB +: 3];
  endfunction

  // Branch offset reuses the DR and SB slots: {ir[11:9], ir[5:3]}
  function automatic logic [5:0] ir_brz_off(input logic [15:0] ir);
    return {ir[IR_DR_LSB +: 3], ir[IR_SB_LSB +: 3]};
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction-memory, data-memory and datapath-control
// signals of the control sequencer.
//   imem_req/imem_addr/imem_ack/imem_data : instruction fetch
//   dmem_req/dmem_we/dmem_ack             : data memory access
//   Z                                     : zero flag from the function unit
//   FS/DA/AA/BA/RW/MD                     : datapath control
//   halted                                : sequencer is in HALT
//
// Handshake: a request is a level held high until the responder raises the
// matching ack for one cycle; the transfer happens in that cycle (ack while
// req is high). An ack seen while the request is low is ignored. There is
// no ready/backpressure in the other direction and no timeout.
interface control_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;
  logic            Z;
  logic [3:0]      FS;
  logic [2:0]      DA;
  logic [2:0]      AA;
  logic [2:0]      BA;
  logic            RW;
  logic            MD;
  logic            halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    output dmem_req, dmem_we,
    input  dmem_ack,
    input  Z,
    output FS, DA, AA, BA, RW, MD, halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    input  dmem_req, dmem_we,
    output dmem_ack,
    output Z,
    input  FS, DA, AA, BA, RW, MD, halted
  );
endinterface

// File: rtl/fs_decoder.sv
// fs_decoder: combinational opcode -> function-select table.
// Ports:
//   i_opcode [3:0] : instruction opcode
//   o_fs     [3:0] : FS code for ALU opcodes, FS_MOVA otherwise
//   o_is_alu       : 1 for register-to-register ALU opcodes (0..B)
module fs_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic [3:0] o_fs,
  output logic       o_is_alu
);

  always_comb begin
    o_fs     = FS_MOVA;
    o_is_alu = 1'b1;
    case (i_opcode)
      OP_MOVA: o_fs = FS_MOVA;
      OP_INC:  o_fs = FS_INC;
      OP_ADD:  o_fs = FS_ADD;
      OP_SUB:  o_fs = FS_SUB;
      OP_DEC:  o_fs = FS_DEC;
      OP_AND:  o_fs = FS_AND;
      OP_OR:   o_fs = FS_OR;
      OP_XOR:  o_fs = FS_XOR;
      OP_NOT:  o_fs = FS_NOT;
      OP_MOVB: o_fs = FS_MOVB;
      OP_SHR:  o_fs = FS_SHR;
      OP_SHL:  o_fs = FS_SHL;
      // LD/ST/BRZ/HALT: A-bus pass-through, no register write-back
      default: begin
        o_fs     = FS_MOVA;
        o_is_alu = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer, one instruction in
// flight: FETCH -> EXEC -> (MEM for LD/ST) -> FETCH; HALT is terminal.
// Ports:
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset
//   bus     : control_sequencer_if.master (memories + datapath control)
//   o_state : current sequencer state, for observation
// All bus outputs are combinational from the state, pc and ir registers
// (plus the acks/Z of the current cycle where a decision depends on them).
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  control_sequencer_if.master  bus,
  output state_t               o_state
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;

  state_t          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [15:0]     w_ir_nxt;

  logic [3:0]        w_op;
  logic [2:0]        w_dr;
  logic [2:0]        w_sa;
  logic [2:0]        w_sb;
  logic signed [5:0] w_off6;
  logic [PC_W-1:0]   w_off;
  logic [3:0]        w_alu_fs;
  logic              w_is_alu;
  logic              w_unused_ir;

  assign w_op   = ir_op(r_ir);
  assign w_dr   = ir_dr(r_ir);
  assign w_sa   = ir_sa(r_ir);
  assign w_sb   = ir_sb(r_ir);
  assign w_off6 = ir_brz_off(r_ir);
  // Signed size cast sign-extends the 6-bit offset to the pc width
  assign w_off  = PC_W'(w_off6);
  assign w_unused_ir = ^r_ir[2:0];

  assign o_state = r_state;

  fs_decoder u_fs_decoder (
    .i_opcode (w_op),
    .o_fs     (w_alu_fs),
    .o_is_alu (w_is_alu)
  );

  // State, pc and ir registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  // Next state and outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    bus.imem_req  = 1'b0;
    bus.imem_addr = r_pc;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.FS        = FS_MOVA;
    bus.DA        = 3'd0;
    bus.AA        = 3'd0;
    bus.BA        = 3'd0;
    bus.RW        = 1'b0;
    bus.MD        = 1'b0;
    bus.halted    = 1'b0;

    unique case (r_state)
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_ir_nxt    = bus.imem_data;
          w_pc_nxt    = r_pc + PC_W'(1);
          w_state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        bus.DA = w_dr;
        bus.AA = w_sa;
        bus.BA = w_sb;
        if (w_is_alu) begin
          bus.FS      = w_alu_fs;
          bus.RW      = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          case (w_op)
            OP_LD, OP_ST: w_state_nxt = ST_MEM;
            OP_BRZ: begin
              // pc already points past the branch; offset is relative to it
              if (bus.Z) w_pc_nxt = r_pc + w_off;
              w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_HALT;
          endcase
        end
      end

      ST_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (w_op == OP_ST);
        bus.AA       = w_sa;
        bus.BA       = w_sb;
        if (bus.dmem_ack) begin
          // Load data is written back only in the completing cycle
          if (w_op == OP_LD) begin
            bus.RW = 1'b1;
            bus.MD = 1'b1;
            bus.DA = w_dr;
          end
          w_state_nxt = ST_FETCH;
        end
      end

      ST_HALT: begin
        bus.halted = 1'b1;
      end

      default: w_state_nxt = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  always #5 clk = ~clk;

  control_sequencer_if #(.PC_W(8)) bus();

  control_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       dmem_req;
    logic       dmem_we;
    logic [3:0] fs;
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       rw;
    logic       md;
    logic       halted;
  } obs_t;

  typedef struct {
    logic [15:0] instr;
    logic        z;
    logic [3:0]  exp_fs;
    logic        exp_rw;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_pc = 8'h00;
  logic [3:0] last_fs;
  logic       last_rw;
  vec_t       vt[15];

  // ---------------- reference model ----------------
  function automatic logic [3:0] spec_fs(input int op);
    case (op)
      0: return 4'b0000;   1: return 4'b0001;   2: return 4'b0010;
      3: return 4'b0101;   4: return 4'b0110;   5: return 4'b1000;
      6: return 4'b1001;   7: return 4'b1010;   8: return 4'b1011;
      9: return 4'b1100;   10: return 4'b1101;  11: return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic obs_t exp_idle(input logic [7:0] pc);
    obs_t e = '0;
    e.imem_addr = pc;
    return e;
  endfunction

  function automatic obs_t exp_fetch(input logic [7:0] pc);
    obs_t e = exp_idle(pc);
    e.imem_req = 1'b1;
    return e;
  endfunction

  function automatic obs_t exp_exec(input logic [15:0] instr, input logic [7:0] pc);
    obs_t e = exp_idle(pc);
    int op = int'(instr[15:12]);
    e.da = instr[11:9];
    e.aa = instr[8:6];
    e.ba = instr[5:3];
    if (op < 12) begin
      e.fs = spec_fs(op);
      e.rw = 1'b1;
    end
    return e;
  endfunction

  function automatic obs_t exp_mem(input logic [15:0] instr, input logic [7:0] pc, input logic ack);
    obs_t e = exp_idle(pc);
    int op = int'(instr[15:12]);
    e.dmem_req = 1'b1;
    e.dmem_we  = (op == 13);
    e.aa = instr[8:6];
    e.ba = instr[5:3];
    if (ack && op == 12) begin
      e.rw = 1'b1;
      e.md = 1'b1;
      e.da = instr[11:9];
    end
    return e;
  endfunction

  function automatic obs_t exp_halt(input logic [7:0] pc);
    obs_t e = exp_idle(pc);
    e.halted = 1'b1;
    return e;
  endfunction

  function automatic obs_t actual();
    obs_t a;
    a.imem_req = bus.imem_req;  a.imem_addr = bus.imem_addr;
    a.dmem_req = bus.dmem_req;  a.dmem_we   = bus.dmem_we;
    a.fs = bus.FS;  a.da = bus.DA;  a.aa = bus.AA;  a.ba = bus.BA;
    a.rw = bus.RW;  a.md = bus.MD;  a.halted = bus.halted;
    return a;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- checkers ----------------
  task automatic check_obs(input string tag, input string stage, input obs_t e);
    obs_t a = actual();
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s/%s: got %h required %h (req,addr,dreq,we,fs,da,aa,ba,rw,md,halted)",
               tag, stage, a, e);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ia, input logic [15:0] id, input logic dk,
                       input logic z, input logic r);
    bus.imem_ack  = ia;
    bus.imem_data = id;
    bus.dmem_ack  = dk;
    bus.Z         = z;
    rst           = r;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(rb(), 16'($urandom), rb(), rb(), 1'b1);
    tick();
    m_pc = 8'h00;
    quiet();
  endtask

  // One full instruction: fetch (with idly wait cycles), exec, optional MEM.
  task automatic run_instr(input string tag, input logic [15:0] instr, input logic z,
                           input int idly, input int ddly);
    int op = int'(instr[15:12]);
    for (int i = 0; i < idly; i++) begin
      drive(1'b0, 16'($urandom), rb(), rb(), 1'b0);
      check_obs(tag, "fetch-wait", exp_fetch(m_pc));
      tick();
    end
    drive(1'b1, instr, rb(), rb(), 1'b0);
    check_obs(tag, "fetch-ack", exp_fetch(m_pc));
    tick();
    m_pc = m_pc + 8'd1;
    drive(rb(), 16'($urandom), rb(), z, 1'b0);
    check_obs(tag, "exec", exp_exec(instr, m_pc));
    last_fs = bus.FS;
    last_rw = bus.RW;
    tick();
    if (op == 14 && z) begin
      int off = int'({instr[11:9], instr[5:3]});
      if (off >= 32) off = off - 64;
      m_pc = 8'(int'(m_pc) + off);
    end
    if (op == 12 || op == 13) begin
      for (int i = 0; i < ddly; i++) begin
        drive(rb(), 16'($urandom), 1'b0, rb(), 1'b0);
        check_obs(tag, "mem-wait", exp_mem(instr, m_pc, 1'b0));
        tick();
      end
      drive(rb(), 16'($urandom), 1'b1, rb(), 1'b0);
      check_obs(tag, "mem-ack", exp_mem(instr, m_pc, 1'b1));
      tick();
    end
  endtask

  task automatic halt_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'(k % 2), 16'($urandom), rb(), rb(), 1'b0);
      check_obs(tag, "halted", exp_halt(m_pc));
      tick();
    end
  endtask

  // ---------------- test ----------------
  initial begin
    obs_t e;
    vt[0]  = '{16'h029A, 1'b0, 4'b0000, 1'b1};
    vt[1]  = '{16'h129A, 1'b0, 4'b0001, 1'b1};
    vt[2]  = '{16'h229A, 1'b0, 4'b0010, 1'b1};
    vt[3]  = '{16'h329A, 1'b0, 4'b0101, 1'b1};
    vt[4]  = '{16'h429A, 1'b0, 4'b0110, 1'b1};
    vt[5]  = '{16'h529A, 1'b0, 4'b1000, 1'b1};
    vt[6]  = '{16'h629A, 1'b0, 4'b1001, 1'b1};
    vt[7]  = '{16'h729A, 1'b0, 4'b1010, 1'b1};
    vt[8]  = '{16'h829A, 1'b0, 4'b1011, 1'b1};
    vt[9]  = '{16'h929A, 1'b0, 4'b1100, 1'b1};
    vt[10] = '{16'hA29A, 1'b0, 4'b1101, 1'b1};
    vt[11] = '{16'hB29A, 1'b0, 4'b1110, 1'b1};
    vt[12] = '{16'hC29A, 1'b0, 4'b0000, 1'b0};
    vt[13] = '{16'hD29A, 1'b0, 4'b0000, 1'b0};
    vt[14] = '{16'hE29A, 1'b1, 4'b0000, 1'b0};

    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();

    // Reset state
    quiet();
    check_obs("reset", "outputs", exp_fetch(8'h00));
    check_val("reset debug state", int'(dbg_state), int'(ST_FETCH));

    // ADD DR=5 SA=1 SB=2, hand-coded expectations
    drive(1'b1, 16'h2A50, 1'b0, 1'b0, 1'b0);
    tick();
    quiet();
    e = '0;
    e.imem_addr = 8'd1; e.fs = 4'b0010; e.da = 3'd5; e.aa = 3'd1; e.ba = 3'd2; e.rw = 1'b1;
    check_obs("add", "exec", e);
    tick();
    quiet();
    check_val("add next imem_addr", int'(bus.imem_addr), 1);
    check_val("add next imem_req", int'(bus.imem_req), 1);
    m_pc = 8'd1;

    // Fetch held for 3 cycles, then LD with 2-cycle data wait
    run_instr("inc-delayed", 16'h1240, 1'b0, 3, 0);
    run_instr("ld", 16'hC640, 1'b0, 0, 2);

    // Opcode table vectors
    for (int i = 0; i < 15; i++) begin
      run_instr("vector", vt[i].instr, vt[i].z, i % 2, 1);
      check_val($sformatf("vector %0d FS", i), int'(last_fs), int'(vt[i].exp_fs));
      check_val($sformatf("vector %0d RW", i), int'(last_rw), int'(vt[i].exp_rw));
    end

    // BRZ at pc=4, offset -3, taken and not taken
    for (int t = 0; t < 2; t++) begin
      do_reset();
      for (int i = 0; i < 4; i++) run_instr("brz-pre", 16'h0000, 1'b0, 0, 0);
      run_instr("brz", 16'hEE28, 1'(1 - t), 0, 0);
      quiet();
      check_val(t == 0 ? "brz taken imem_addr" : "brz not-taken imem_addr",
                int'(bus.imem_addr), t == 0 ? 2 : 5);
    end

    // Reset during ST MEM together with dmem_ack
    do_reset();
    drive(1'b1, 16'hD650, 1'b0, 1'b0, 1'b0);
    check_obs("st-rst", "fetch", exp_fetch(8'h00));
    tick();
    m_pc = 8'd1;
    quiet();
    check_obs("st-rst", "exec", exp_exec(16'hD650, m_pc));
    tick();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    check_obs("st-rst", "mem", exp_mem(16'hD650, m_pc, 1'b1));
    tick();
    m_pc = 8'h00;
    quiet();
    check_obs("st-rst", "after", exp_fetch(8'h00));

    // HALT, then reset releases it
    run_instr("halt", 16'hF000, 1'b0, 0, 0);
    halt_cycles("halt", 8);
    do_reset();
    check_val("halt released halted", int'(bus.halted), 0);
    check_val("halt released imem_req", int'(bus.imem_req), 1);

    // Randomized instruction stream against the model
    for (int n = 0; n < 300; n++) begin
      logic [15:0] instr = 16'($urandom);
      run_instr("random", instr, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
      if (instr[15:12] == 4'hF) begin
        halt_cycles("random", 3);
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
